// File: rtl/filter_ctrl_pkg.sv
// Shared filter-mode types: mode enumeration, 3-bit state word constants and the encoder.
// Also used by the downstream filter state machine.
package filter_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        IIR  = 2'd2,
        FIR  = 2'd3
    } mode_e;

    // State word bits: [0] enable, [1] filter on, [2] 1=IIR / 0=FIR
    localparam logic [2:0] STATE_OFF  = 3'b000;
    localparam logic [2:0] STATE_IDLE = 3'b001;
    localparam logic [2:0] STATE_FIR  = 3'b011;
    localparam logic [2:0] STATE_IIR  = 3'b111;

    function automatic logic [2:0] encode_mode(input mode_e m);
        logic [2:0] s;
        case (m)
            IDLE:    s = STATE_IDLE;
            IIR:     s = STATE_IIR;
            FIR:     s = STATE_FIR;
            default: s = STATE_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces one raw push-button; emits the stable level and a
// one-cycle pulse on each accepted press (rising edge of the stable level).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   level_d_q;
    logic                   press_q;
    logic                   btn_sync;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            // Any cycle agreeing with the stable level restarts the qualification window
            if (btn_sync == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                level_q <= btn_sync;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            level_d_q <= level_q;
            press_q   <= level_q & ~level_d_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/filter_mode_ctrl.sv
// Button-driven OFF/IDLE/IIR/FIR mode controller; applies the mode to state_o only on sample strobes.
// Optional IDLE auto-off timeout is enabled by defining FMC_AUTO_OFF_EN.
module filter_mode_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int SYNC_STAGES          = 2,
    parameter int IDLE_TIMEOUT_STROBES = 48000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_power_i,
    input  logic       btn_mode_i,
    input  logic       sample_strobe_i,
    output logic [2:0] state_o,
    output logic       pending_o,
    output logic       mode_changed_o
);

    logic       power_press;
    logic       mode_press;
    logic       unused_power_level;
    logic       unused_mode_level;
    logic       timeout_hit;
    mode_e      mode_q;
    mode_e      mode_d;
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       changed_q;
    logic       changed_d;
    logic       pending_q;
    logic       pending_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_db_power (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_power_i),
        .level_o (unused_power_level),
        .press_o (power_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_db_mode (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_mode_i),
        .level_o (unused_mode_level),
        .press_o (mode_press)
    );

`ifdef FMC_AUTO_OFF_EN
    localparam int TW = $clog2(IDLE_TIMEOUT_STROBES + 1);
    logic [TW-1:0] idle_cnt_q;

    assign timeout_hit = (mode_q == IDLE) && sample_strobe_i &&
                         (idle_cnt_q == TW'(IDLE_TIMEOUT_STROBES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt_q <= '0;
        end else if (power_press || mode_press || (mode_q != IDLE) || timeout_hit) begin
            idle_cnt_q <= '0;
        end else if (sample_strobe_i) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_idle_timeout = IDLE_TIMEOUT_STROBES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q    <= OFF;
            state_q   <= STATE_OFF;
            changed_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            state_q   <= state_d;
            changed_q <= changed_d;
            pending_q <= pending_d;
        end
    end

    // Power press dominates a simultaneous mode press; a press also beats the timeout
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            OFF:  if (power_press) mode_d = IDLE;
            IDLE: begin
                if (power_press)      mode_d = OFF;
                else if (mode_press)  mode_d = IIR;
                else if (timeout_hit) mode_d = OFF;
            end
            IIR: begin
                if (power_press)     mode_d = OFF;
                else if (mode_press) mode_d = FIR;
            end
            FIR: begin
                if (power_press)     mode_d = OFF;
                else if (mode_press) mode_d = IDLE;
            end
            default: mode_d = OFF;
        endcase
    end

    // The strobe samples the pre-update mode_q; pending tracks the post-edge relation
    always_comb begin
        state_d   = state_q;
        changed_d = 1'b0;
        if (sample_strobe_i && (encode_mode(mode_q) != state_q)) begin
            state_d   = encode_mode(mode_q);
            changed_d = 1'b1;
        end
        pending_d = (encode_mode(mode_d) != state_d);
    end

    assign state_o        = state_q;
    assign pending_o      = pending_q;
    assign mode_changed_o = changed_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Directed bench for filter_mode_ctrl with short debounce; expectations follow FMC_AUTO_OFF_EN.
module tb_filter_mode_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       btn_power_i = 1'b0;
    logic       btn_mode_i = 1'b0;
    logic       sample_strobe_i = 1'b0;
    logic [2:0] state_o;
    logic       pending_o;
    logic       mode_changed_o;

    int checks = 0;
    int errors = 0;

    filter_mode_ctrl #(
        .DEBOUNCE_CYCLES      (4),
        .SYNC_STAGES          (2),
        .IDLE_TIMEOUT_STROBES (3)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .btn_power_i     (btn_power_i),
        .btn_mode_i      (btn_mode_i),
        .sample_strobe_i (sample_strobe_i),
        .state_o         (state_o),
        .pending_o       (pending_o),
        .mode_changed_o  (mode_changed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic release_btns();
        btn_power_i = 1'b0;
        btn_mode_i  = 1'b0;
        tick(12);
    endtask

    task automatic press(input logic pw, input logic md);
        btn_power_i = pw;
        btn_mode_i  = md;
        tick(10);
        release_btns();
    endtask

    // One strobe cycle, then check outputs right after it and one cycle later
    task automatic strobe(input string tag, input logic [2:0] exp_state,
                          input logic exp_changed, input logic exp_pending);
        sample_strobe_i = 1'b1;
        tick(1);
        sample_strobe_i = 1'b0;
        check({tag, "_state"}, state_o, exp_state);
        check({tag, "_changed"}, {2'b0, mode_changed_o}, {2'b0, exp_changed});
        check({tag, "_pending"}, {2'b0, pending_o}, {2'b0, exp_pending});
        tick(1);
        check({tag, "_changed_drop"}, {2'b0, mode_changed_o}, 3'b000);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_state", state_o, 3'b000);
        check("rst_pending", {2'b0, pending_o}, 3'b000);
        check("rst_changed", {2'b0, mode_changed_o}, 3'b000);
        rst_i = 1'b0;
        tick(2);

        // Glitches: 3 cycles high, then 2 high / 1 low / 2 high
        btn_power_i = 1'b1;
        tick(3);
        release_btns();
        check("glitch3_pending", {2'b0, pending_o}, 3'b000);
        btn_power_i = 1'b1;
        tick(2);
        btn_power_i = 1'b0;
        tick(1);
        btn_power_i = 1'b1;
        tick(2);
        release_btns();
        check("glitch212_pending", {2'b0, pending_o}, 3'b000);
        strobe("glitch_strobe", 3'b000, 1'b0, 1'b0);

        // Power held 10 cycles: pending before strobe, applied at strobe
        btn_power_i = 1'b1;
        tick(10);
        check("pwr_hold_pending", {2'b0, pending_o}, 3'b001);
        check("pwr_hold_state", state_o, 3'b000);
        release_btns();
        strobe("pwr_on", 3'b001, 1'b1, 1'b0);
        strobe("pwr_on_again", 3'b001, 1'b0, 1'b0);

        // Mode cycle IDLE -> IIR -> FIR -> IDLE, a strobe after each press
        press(1'b0, 1'b1);
        check("mode1_pending", {2'b0, pending_o}, 3'b001);
        strobe("mode_iir", 3'b111, 1'b1, 1'b0);
        press(1'b0, 1'b1);
        strobe("mode_fir", 3'b011, 1'b1, 1'b0);
        press(1'b0, 1'b1);
        strobe("mode_idle", 3'b001, 1'b1, 1'b0);

        // Two presses before one strobe: IIR skipped
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        strobe("skip_to_fir", 3'b011, 1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        strobe("back_to_iir", 3'b111, 1'b1, 1'b0);

        // Power and mode together in IIR: power wins
        press(1'b1, 1'b1);
        strobe("pwr_mode_both", 3'b000, 1'b1, 1'b0);

        // Reset mid-debounce while IDLE is applied
        press(1'b1, 1'b0);
        strobe("pre_rst_on", 3'b001, 1'b1, 1'b0);
        btn_power_i = 1'b1;
        tick(5);
        rst_i = 1'b1;
        #1;
        check("midrst_state", state_o, 3'b000);
        check("midrst_pending", {2'b0, pending_o}, 3'b000);
        check("midrst_changed", {2'b0, mode_changed_o}, 3'b000);
        btn_power_i = 1'b0;
        tick(2);
        rst_i = 1'b0;
        tick(15);
        check("post_rst_pending", {2'b0, pending_o}, 3'b000);
        strobe("post_rst_strobe", 3'b000, 1'b0, 1'b0);

        // IDLE auto-off after the third strobe (only with FMC_AUTO_OFF_EN)
        press(1'b1, 1'b0);
        strobe("to_s1", 3'b001, 1'b1, 1'b0);
        strobe("to_s2", 3'b001, 1'b0, 1'b0);
`ifdef FMC_AUTO_OFF_EN
        strobe("to_s3", 3'b001, 1'b0, 1'b1);
        strobe("to_s4", 3'b000, 1'b1, 1'b0);
`else
        strobe("to_s3", 3'b001, 1'b0, 1'b0);
        strobe("to_s4", 3'b001, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
